// File: rtl/sdf_delay_line_var.sv
// Runtime-depth complex circular delay line for R2SDF feedback; output valid one clock after the matching accept.
// No backpressure: di_en low stalls the line in place, and flush/rst discard every held sample.
module sdf_delay_line_var #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DEPTH  = 256,
  parameter int DEPTH_W    = $clog2(MAX_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEPTH_W-1:0]    cfg_depth,
  input  logic                  flush,
  input  logic                  di_en,
  input  logic [DATA_WIDTH-1:0] di_re,
  input  logic [DATA_WIDTH-1:0] di_im,
  output logic                  do_en,
  output logic [DATA_WIDTH-1:0] do_re,
  output logic [DATA_WIDTH-1:0] do_im,
  output logic [DEPTH_W-1:0]    fill_cnt,
  output logic                  full
);

  localparam int AW = $clog2(MAX_DEPTH);

  logic [DATA_WIDTH-1:0] ram_re [MAX_DEPTH];
  logic [DATA_WIDTH-1:0] ram_im [MAX_DEPTH];

  logic [AW-1:0]         ptr_q,   ptr_d;
  logic [DEPTH_W-1:0]    depth_q, depth_d;
  logic [DEPTH_W-1:0]    fill_q,  fill_d;
  logic                  do_en_q, do_en_d;
  logic [DATA_WIDTH-1:0] do_re_q, do_re_d;
  logic [DATA_WIDTH-1:0] do_im_q, do_im_d;
  logic [DEPTH_W-1:0]    cfg_clamped;
  logic                  full_w;
  logic                  accept;

  always_comb begin
    cfg_clamped = cfg_depth;
    if (cfg_depth == '0) begin
      cfg_clamped = DEPTH_W'(1);
    end else if (cfg_depth > DEPTH_W'(MAX_DEPTH)) begin
      cfg_clamped = DEPTH_W'(MAX_DEPTH);
    end
  end

  assign full_w = (fill_q == depth_q);
  assign accept = di_en && !flush;

  always_comb begin
    ptr_d   = ptr_q;
    depth_d = depth_q;
    fill_d  = fill_q;
    do_en_d = 1'b0;
    do_re_d = do_re_q;
    do_im_d = do_im_q;
    if (flush) begin
      ptr_d   = '0;
      fill_d  = '0;
      depth_d = cfg_clamped;
    end else if (di_en) begin
      // Wrap at the active depth, not at the RAM size.
      if (DEPTH_W'(ptr_q) == depth_q - DEPTH_W'(1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + AW'(1);
      end
      fill_d  = full_w ? fill_q : fill_q + DEPTH_W'(1);
      do_en_d = full_w;
      do_re_d = ram_re[ptr_q];
      do_im_d = ram_im[ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      depth_q <= cfg_clamped;
      fill_q  <= '0;
      do_en_q <= 1'b0;
      do_re_q <= '0;
      do_im_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      fill_q  <= fill_d;
      do_en_q <= do_en_d;
      do_re_q <= do_re_d;
      do_im_q <= do_im_d;
    end
  end

  // Storage is never cleared; the read above sees the pre-write word (read-first).
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      ram_re[ptr_q] <= di_re;
      ram_im[ptr_q] <= di_im;
    end
  end

  assign do_en    = do_en_q;
  assign do_re    = do_re_q;
  assign do_im    = do_im_q;
  assign fill_cnt = fill_q;
  assign full     = full_w;

endmodule

// File: tb/tb_sdf_delay_line_var.sv
// Randomized scoreboard bench for sdf_delay_line_var against a queue-based delay model.
module tb_sdf_delay_line_var;

  localparam int DW   = 16;
  localparam int MAXD = 256;
  localparam int DWD  = $clog2(MAXD) + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [DWD-1:0] cfg_depth = '0;
  logic           flush = 1'b0;
  logic           di_en = 1'b0;
  logic [DW-1:0]  di_re = '0;
  logic [DW-1:0]  di_im = '0;
  logic           do_en;
  logic [DW-1:0]  do_re;
  logic [DW-1:0]  do_im;
  logic [DWD-1:0] fill_cnt;
  logic           full;

  sdf_delay_line_var #(.DATA_WIDTH(DW), .MAX_DEPTH(MAXD), .DEPTH_W(DWD)) dut (
    .clk(clk), .rst(rst), .cfg_depth(cfg_depth), .flush(flush),
    .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_en(do_en), .do_re(do_re), .do_im(do_im),
    .fill_cnt(fill_cnt), .full(full)
  );

  always #5 clk = ~clk;

  // Model: samples currently held in the line, oldest first.
  logic [31:0] held[$];
  logic [31:0] exp_q[$];
  int          model_depth = 1;
  bit          hold_known = 1'b0;
  logic [31:0] hold_val = '0;
  bit          started = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic int clamp(int c);
    if (c == 0) return 1;
    if (c > MAXD) return MAXD;
    return c;
  endfunction

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(bit r, bit f, bit en, logic [DW-1:0] re, logic [DW-1:0] im, int cfg);
    @(negedge clk);
    rst = r; flush = f; di_en = en; di_re = re; di_im = im;
    cfg_depth = DWD'(cfg);
    if (r) begin
      started = 1'b1;
      held.delete();
      model_depth = clamp(cfg);
      hold_known = 1'b1;
      hold_val = '0;
    end else if (f) begin
      held.delete();
      model_depth = clamp(cfg);
    end else if (en) begin
      if (held.size() == model_depth) begin
        hold_val = held.pop_front();
        exp_q.push_back(hold_val);
        hold_known = 1'b1;
      end else begin
        hold_known = 1'b0;
      end
      held.push_back({re, im});
    end
  endtask

  task automatic acc(logic [DW-1:0] re, int cfg);
    step(1'b0, 1'b0, 1'b1, re, DW'($urandom), cfg);
  endtask

  task automatic idle(int cfg);
    step(1'b0, 1'b0, 1'b0, DW'($urandom), DW'($urandom), cfg);
  endtask

  // Monitor: one check set per clock, sampled just after the active edge.
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        chk("do_en", int'(do_en), int'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (do_en) begin
            chk("do_re", int'(do_re), int'(e[31:16]));
            chk("do_im", int'(do_im), int'(e[15:0]));
          end
        end else if (hold_known) begin
          chk("hold_re", int'(do_re), int'(hold_val[31:16]));
          chk("hold_im", int'(do_im), int'(hold_val[15:0]));
        end
        chk("fill_cnt", int'(fill_cnt), held.size());
        chk("full", int'(full), int'(held.size() == model_depth));
      end
    end
  end

  initial begin
    int cfg;
    // Basic delay at depth 4 with a ramp.
    step(1'b1, 1'b0, 1'b0, '0, '0, 4);
    for (int i = 1; i <= 12; i++) acc(DW'(i), 4);
    // Stall gap after sample 5.
    step(1'b0, 1'b1, 1'b0, '0, '0, 4);
    for (int i = 1; i <= 5; i++) acc(DW'(i), 4);
    for (int i = 0; i < 3; i++) idle(4);
    for (int i = 6; i <= 10; i++) acc(DW'(i), 4);
    // Depth request changed without flush is ignored, then applied by flush.
    for (int i = 0; i < 10; i++) acc(DW'($urandom), 8);
    step(1'b0, 1'b1, 1'b0, '0, '0, 8);
    for (int i = 1; i <= 20; i++) acc(DW'(i + 100), 8);
    // Depth 0 clamps to 1.
    step(1'b0, 1'b1, 1'b0, '0, '0, 0);
    for (int i = 0; i < 10; i++) acc(DW'($urandom), 0);
    // Oversized request clamps to MAX_DEPTH; three full wraps with a few stalls.
    step(1'b1, 1'b0, 1'b0, '0, '0, 300);
    for (int i = 0; i < 3 * MAXD + 20; i++) begin
      if ($urandom_range(0, 15) == 0) idle(300);
      acc(DW'($urandom), 300);
    end
    // Flush in the same cycle as a write: the sample must be dropped.
    step(1'b0, 1'b1, 1'b1, 16'h7FFF, 16'h7FFF, 3);
    for (int i = 0; i < 20; i++) acc(DW'($urandom_range(0, 16'h7FFE)), 3);
    // Reset mid-stream while full at depth 16.
    step(1'b1, 1'b0, 1'b0, '0, '0, 16);
    for (int i = 0; i < 20; i++) acc(DW'($urandom), 16);
    step(1'b1, 1'b0, 1'b1, DW'($urandom), DW'($urandom), 16);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) idle(16);
      acc(DW'($urandom), 16);
    end
    // Random mix of stalls, flushes and depth changes.
    cfg = 5;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        cfg = (i % 3 == 0) ? int'($urandom_range(0, 2 * MAXD - 1)) : int'($urandom_range(0, 20));
        step(1'b0, 1'b1, $urandom_range(0, 1) == 1, DW'($urandom), DW'($urandom), cfg);
      end else if ($urandom_range(0, 9) < 7) begin
        acc(DW'($urandom), int'($urandom_range(0, 2 * MAXD - 1)));
      end else begin
        idle(int'($urandom_range(0, 2 * MAXD - 1)));
      end
    end
    idle(cfg);
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdf_delay_line_var.md
Name: sdf_delay_line_var

Overview:
- Parametrised successor to the fixed-depth SDF feedback delay.
- Complex (re/im) circular delay line built on a dual-port RAM.
- Depth is runtime-programmable up to MAX_DEPTH, so one instance serves multiple FFT sizes.
- Adds an input-valid stall, a synchronous flush, fill status and a registered output-valid.
- Sits in each R2SDF stage between the butterfly output and the butterfly feedback input.

Parameters:
- DATA_WIDTH, 16: width of each of re/im.
- MAX_DEPTH, 256: RAM entries; power of two, ≥2.
- DEPTH_W, $clog2(MAX_DEPTH)+1: width of cfg_depth and fill_cnt.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- cfg_depth  in  DEPTH_W  requested delay in samples; captured only at rst or flush.
- flush  in  1  synchronous clear of pointer/fill state; captures cfg_depth.
- di_en  in  1  input sample valid; line advances only when high.
- di_re  in  DATA_WIDTH  input real part.
- di_im  in  DATA_WIDTH  input imaginary part.
- do_en  out  1  output sample valid.
- do_re  out  DATA_WIDTH  delayed real part.
- do_im  out  DATA_WIDTH  delayed imaginary part.
- fill_cnt  out  DEPTH_W  samples held, saturates at active depth.
- full  out  1  fill_cnt == active depth.

Behaviour:
- Reset, with rst=1 at a clock edge:
  - ptr=0, fill_cnt=0, full=0, do_en=0, do_re=do_im=0.
  - depth_r <= clamp(cfg_depth).
  - RAM contents are not cleared.
- Clamp rule: cfg_depth=0 gives 1; cfg_depth>MAX_DEPTH gives MAX_DEPTH; otherwise unchanged.
- Changes to cfg_depth outside rst/flush are ignored.
- Storage: one RAM per component, MAX_DEPTH x DATA_WIDTH.
  - Read and write both use ptr.
  - Read-during-write to the same address must return OLD data (read-first).
- Accept cycle (di_en=1, flush=0, rst=0):
  - Write di at ptr.
  - Read at ptr, registered into do_re/do_im at the next edge.
  - ptr <= (ptr == depth_r-1) ? 0 : ptr+1.
  - fill_cnt <= min(fill_cnt+1, depth_r).
- Output-valid timing:
  - do_en is registered and equals (di_en && full) from the previous cycle, where full is sampled before that cycle's update.
  - The k-th accepted sample (k from 0) appears on do_re/do_im with do_en=1 one clock after accept number k+depth_r.
  - Latency in accepted samples = depth_r; latency in clocks after the matching accept = 1.
- Stall (di_en=0):
  - ptr, fill_cnt and RAM are unchanged.
  - do_en=0 next cycle.
  - do_re/do_im hold their last value.
- Flush (flush=1, rst=0):
  - ptr=0, fill_cnt=0, full=0, do_en=0 next cycle; depth_r <= clamp(cfg_depth).
  - di_en in the same cycle is ignored (no write).
  - do_re/do_im hold.
- Priority: rst > flush > di_en.
- depth_r=1: full after the first accept; each output equals the input accepted on the previous accept.
- Wrap: ptr wraps at depth_r-1, never at MAX_DEPTH unless depth_r=MAX_DEPTH.
- Mid-operation reset or flush discards all held samples. No stale do_en may appear afterwards until depth_r new accepts have occurred.
- Data is passed through bit-exact: no arithmetic, rounding or sign handling.

Test Plan:
- Basic delay: rst with cfg_depth=4, then di_en=1 continuously, di_re=1,2,3,…
  - do_en first rises one clock after the 5th accept, with do_re=1.
  - Thereafter do_re = di_re − 4 each clock.
  - fill_cnt goes 1,2,3,4 then stays 4.
- Stall: depth 4, feed 1..6 with di_en=0 for 3 cycles after sample 5.
  - do_en=0 and do_re holds 1 during the gap.
  - The next accept (6) yields do_re=2.
- Runtime depth change: at depth 4 after 10 samples, set cfg_depth=8 without flush; behaviour is unchanged.
  - Then pulse flush: fill_cnt=0 and do_en=0.
  - First output after flush is the 1st post-flush sample, one clock after the 9th post-flush accept.
- Clamp/edge depths:
  - cfg_depth=0 acts as depth 1; output is the previous accepted input.
  - cfg_depth=300 with MAX_DEPTH=256 acts as 256; first do_en after 257 accepts.
  - Wrap is verified over 3 full passes.
- Flush + di_en same cycle: flush=1, di_en=1, di_re=0x7FFF.
  - 0x7FFF is never output.
  - fill_cnt=0 the next cycle.
- Reset mid-stream: rst asserted for 1 cycle while full at depth 16.
  - All outputs are 0 next cycle.
  - No do_en until 17 further accepts.
  - Output values all come from post-reset inputs.
